// File: rtl/button_conditioner.sv
// button_conditioner: synchronise, debounce and pulse-convert the seven board keys.
// Define BUTTON_AUTOREPEAT_EN to add hold-to-repeat on the four direction keys.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter bit ACTIVE_LOW_IN   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] key_raw,
    output logic       up_button,
    output logic       down_button,
    output logic       left_button,
    output logic       right_button,
    output logic       start_button,
    output logic       a_button,
    output logic       b_button,
    output logic [6:0] held
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
`ifdef BUTTON_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;
`endif
    logic [6:0] pulse;
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_param
        $error("button_conditioner: cycle parameters must be >= 2");
    end
    for (genvar k = 0; k < 7; k++) begin : g_key
        logic p, s1, s, h, pls, match, h_nx, press_nx, rpt_nx;
        logic [CW-1:0] cnt, cnt_nx;
        assign p = ACTIVE_LOW_IN ? ~key_raw[k] : key_raw[k];
        always_comb begin
            match    = cnt == CW'(DEBOUNCE_CYCLES - 1);
            h_nx     = (s != h && match) ? s : h;
            cnt_nx   = (s == h || match) ? '0 : cnt + 1'b1;
            press_nx = s && !h && match;
        end
        // The pulse flop is loaded alongside the 0->1 update of held.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                s1  <= 1'b0;
                s   <= 1'b0;
                h   <= 1'b0;
                cnt <= '0;
                pls <= 1'b0;
            end else begin
                s1  <= p;
                s   <= s1;
                h   <= h_nx;
                cnt <= cnt_nx;
                pls <= press_nx | rpt_nx;
            end
        end
        assign held[k]  = h;
        assign pulse[k] = pls;
`ifdef BUTTON_AUTOREPEAT_EN
        if (k < 4) begin : g_rpt
            rpt_state_t st, st_nx;
            logic [RW-1:0] rcnt, rcnt_nx;
            // Looking at next-cycle held lets release cancel a repeat landing on the same edge.
            always_comb begin
                st_nx   = st;
                rcnt_nx = rcnt + 1'b1;
                rpt_nx  = 1'b0;
                if (!h_nx) begin
                    st_nx   = IDLE;
                    rcnt_nx = '0;
                end else if (press_nx) begin
                    st_nx   = DELAY;
                    rcnt_nx = '0;
                end else if (st == IDLE) begin
                    rcnt_nx = '0;
                end else if (st == DELAY && rcnt == RW'(REPEAT_DELAY - 1)) begin
                    st_nx   = REPEAT;
                    rcnt_nx = '0;
                    rpt_nx  = 1'b1;
                end else if (st == REPEAT && rcnt == RW'(REPEAT_PERIOD - 1)) begin
                    rcnt_nx = '0;
                    rpt_nx  = 1'b1;
                end
            end
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    st   <= IDLE;
                    rcnt <= '0;
                end else begin
                    st   <= st_nx;
                    rcnt <= rcnt_nx;
                end
            end
        end else begin : g_norpt
            assign rpt_nx = 1'b0;
        end
`else
        assign rpt_nx = 1'b0;
`endif
    end
    assign {b_button, a_button, start_button, right_button, left_button, down_button, up_button} = pulse;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed stimulus with a queue of expected (cycle, key) pulses
// drained by an independent monitor; works with or without BUTTON_AUTOREPEAT_EN.
module tb_button_conditioner;
    localparam int DB = 4, RD = 10, RP = 3;
    logic clk = 1'b0, reset = 1'b0;
    logic [6:0] key_raw = 7'h7f;
    logic up_button, down_button, left_button, right_button, start_button, a_button, b_button;
    logic [6:0] held, pulse;
    int cyc = 0, total = 0, bad = 0;
    typedef struct {int t; int k;} exp_t;
    exp_t q[$];

    button_conditioner #(
        .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .ACTIVE_LOW_IN(1)
    ) dut (
        .clk(clk), .reset(reset), .key_raw(key_raw),
        .up_button(up_button), .down_button(down_button), .left_button(left_button),
        .right_button(right_button), .start_button(start_button), .a_button(a_button),
        .b_button(b_button), .held(held)
    );

    assign pulse = {b_button, a_button, start_button, right_button, left_button, down_button, up_button};
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every observed pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].t < cyc) begin
            total++;
            bad++;
            $display("FAIL missed_pulse key=%0d got=none required_cycle=%0d now=%0d", q[0].k, q[0].t, cyc);
            void'(q.pop_front());
        end
        for (int k = 0; k < 7; k++) begin
            if (pulse[k]) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pulse key=%0d cycle=%0d required=no_pulse", k, cyc);
                end else if (q[0].t != cyc || q[0].k != k) begin
                    bad++;
                    $display("FAIL pulse got key=%0d cycle=%0d required key=%0d cycle=%0d", k, cyc, q[0].k, q[0].t);
                end else begin
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic void push(int t, int k);
        int i = 0;
        while (i < q.size() && (q[i].t < t || (q[i].t == t && q[i].k < k))) i++;
        q.insert(i, exp_t'{t, k});
    endfunction

    // Key driven low at cycle c and high again at cycle rel: press pulse at c+DB+2,
    // repeats (direction keys only) every RP after the first at +RD, until held falls at rel+DB+2.
    function automatic void exp_press(int k, int c, int rel);
        push(c + DB + 2, k);
`ifdef BUTTON_AUTOREPEAT_EN
        if (k < 4)
            for (int t = c + DB + 2 + RD; t < rel + DB + 2; t += RP) push(t, k);
`else
        if (rel < c) $display("note: bad release cycle");
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%b required=%b", name, act, req);
        end
    endtask

    initial begin
        int c, r;
        tick(2);
        chk("reset_held", held, 7'h00);
        chk("reset_pulse", pulse, 7'h00);
        reset = 1'b1;
        tick(3);
        // clean press on a
        c = cyc;
        key_raw[5] = 1'b0;
        exp_press(5, c, c + 20);
        tick(DB + 1);
        chk("a_held_before", held, 7'h00);
        tick(1);
        chk("a_held_press", held, 7'h20);
        tick(13);
        chk("a_held_hold", held, 7'h20);
        key_raw[5] = 1'b1;
        tick(DB + 2);
        chk("a_held_release", held, 7'h00);
        tick(4);
        // bounce on start: low glitches of DB-1 cycles must be absorbed
        for (int i = 0; i < 3; i++) begin
            key_raw[4] = 1'b0;
            tick(DB - 1);
            key_raw[4] = 1'b1;
            tick(3);
        end
        chk("start_bounce_held", held, 7'h00);
        c = cyc;
        key_raw[4] = 1'b0;
        push(c + DB + 2, 4);
        tick(DB + 2);
        chk("start_held", held, 7'h10);
        tick(24);
        key_raw[4] = 1'b1;
        tick(DB + 6);
        chk("start_release", held, 7'h00);
        // up held 40 cycles: repeats only with the macro defined
        c = cyc;
        key_raw[0] = 1'b0;
        exp_press(0, c, c + 40);
        tick(20);
        chk("up_held_mid", held, 7'h01);
        tick(20);
        key_raw[0] = 1'b1;
        tick(DB + 2);
        chk("up_release", held, 7'h00);
        tick(8);
        // down and b on the same edge
        c = cyc;
        key_raw[1] = 1'b0;
        key_raw[6] = 1'b0;
        exp_press(1, c, c + 20);
        exp_press(6, c, c + 20);
        tick(20);
        chk("simul_held", held, 7'h42);
        key_raw[1] = 1'b1;
        key_raw[6] = 1'b1;
        tick(12);
        chk("simul_release", held, 7'h00);
        // reset two cycles after the right pulse, key still held
        c = cyc;
        key_raw[3] = 1'b0;
        push(c + DB + 2, 3);
        tick(DB + 4);
        reset = 1'b0;
        #1;
        chk("rst_async_held", held, 7'h00);
        chk("rst_async_pulse", pulse, 7'h00);
        tick(2);
        chk("rst_held", held, 7'h00);
        chk("rst_pulse", pulse, 7'h00);
        r = cyc;
        reset = 1'b1;
        exp_press(3, r, r + 8);
        tick(DB + 2);
        chk("rst_repress_held", held, 7'h08);
        tick(2);
        key_raw[3] = 1'b1;
        tick(12);
        chk("rst_release", held, 7'h00);
        tick(5);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL pending_expectations got=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end input stage for the sudoku game: takes the seven raw board push-buttons, synchronises and debounces each one, and produces the single-cycle press pulses (`up_button` … `b_button`) that the game state machine, board updater, position updater and difficulty selector consume. It sits between the FPGA pins and the game state machine. It optionally auto-repeats the four direction buttons so a held key keeps moving the cursor or cycling digits.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 500000: consecutive cycles a synchronised input must differ from the debounced state before that state flips (10 ms at 50 MHz); legal range ≥ 2.
- `REPEAT_DELAY`, 25000000: cycles from press pulse to first repeat pulse; legal range ≥ 2.
- `REPEAT_PERIOD`, 5000000: cycles between subsequent repeat pulses; legal range ≥ 2.
- `ACTIVE_LOW_IN`, 1: 1 = raw keys read 0 when pressed (inverted on entry); 0 = active-high keys.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `key_raw`  in  7  raw pins. Bit 0 = up, 1 = down, 2 = left, 3 = right, 4 = start, 5 = a, 6 = b.
- `up_button`, `down_button`, `left_button`, `right_button`, `start_button`, `a_button`, `b_button`  out  1 each  one-cycle press pulses.
- `held`  out  7  debounced level per key, in `key_raw` bit order; 1 = pressed.

## Operation
- Per key, a fixed pipeline runs independently; simultaneous presses on different keys are fully independent.
- Polarity: the input is inverted when `ACTIVE_LOW_IN` = 1, giving internal `p` (1 = pressed).
- Synchroniser: two flip-flops, `s1` then `s`. Both reset to 0 (released).
- Debounce counter `cnt`, width `$clog2(DEBOUNCE_CYCLES)`:
  - while `s == held[k]`: `cnt` ← 0.
  - while they differ: `cnt` increments.
  - on the cycle `cnt == DEBOUNCE_CYCLES-1` with a mismatch: `held[k]` ← `s`, `cnt` ← 0.
  - Any glitch shorter than `DEBOUNCE_CYCLES` cycles restarts the count and never reaches `held`.
- Press pulse: asserted for exactly the one cycle in which `held[k]` first reads 1, i.e. it is registered together with the 0→1 update of `held`. Release (1→0) produces no pulse.
- Per-direction repeat FSM (keys 0–3, only with `AUTOREPEAT_EN`):
  - IDLE: entered whenever `held[k]` = 0; counter `rcnt` cleared.
  - DELAY: entered on the press pulse. `rcnt` counts up; at `REPEAT_DELAY-1` it emits a pulse, clears `rcnt`, and moves to REPEAT.
  - REPEAT: `rcnt` counts up; at `REPEAT_PERIOD-1` it emits a pulse and clears `rcnt`.
  - Release (`held` falls): back to IDLE in the same cycle. No further pulse after `held` is 0.
- Start, a and b never repeat.
- Output pulse = press pulse OR repeat pulse. The two are never coincident by construction.
- Held through reset: a key held while `reset` deasserts is seen as a new press and yields a pulse after the normal latency.

## Timing
- Reset values: all pulses 0, `held` = 0, synchronisers 0, counters 0, repeat FSMs IDLE.
- Reset mid-operation:
  - asynchronous clear of all state.
  - any pulse in flight is dropped.
  - no pulse is emitted on the reset cycle.
- Press latency: raw edge stable before clock edge E → `s` = 1 after edge E+1 → `held` and the pulse are high after edge E+1+`DEBOUNCE_CYCLES`. The pulse stays high one cycle.
- Release latency: same path; `held` falls after edge E+1+`DEBOUNCE_CYCLES`.
- First repeat: `REPEAT_DELAY` cycles after the press-pulse cycle. Subsequent repeats every `REPEAT_PERIOD` cycles.
- The minimum spacing between pulses on one key is 2 cycles, because all parameters are ≥ 2.
- Outputs are registered; there is no combinational path from `key_raw` to any output.

## Configuration
- `BUTTON_AUTOREPEAT_EN` defined: repeat FSMs and counters for keys 0–3 are compiled in, with behaviour as above.
- Undefined: no repeat logic is synthesised. Every key produces exactly one pulse per debounced press; `REPEAT_DELAY` and `REPEAT_PERIOD` are ignored.

## Test plan
Common bench parameters: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3, `ACTIVE_LOW_IN`=1.
- Clean press: drive `key_raw[5]` 1→0 before edge 0 and hold → `a_button` high only in the cycle after edge 5, `held[5]` = 1 from then on; no pulse on release.
- Bounce: `key_raw[4]` toggles with low periods of 3 cycles, then holds low → no `start_button` pulse during the bounce, then exactly one pulse 5 edges after the final stable low.
- Auto-repeat (macro defined): hold `key_raw[0]` low for 40 cycles → `up_button` pulses at press cycle P, then P+10, P+13, P+16 … while held. After release, no pulse once `held[0]` = 0.
- Auto-repeat off (macro undefined, same stimulus) → a single `up_button` pulse at P only.
- Simultaneous: `key_raw[1]` and `key_raw[6]` pressed on the same edge → `down_button` and `b_button` pulse in the same cycle; `b_button` never repeats.
- Reset mid-press: assert `reset` (low) 2 cycles after pulse P while the key is still held, then release `reset` → all outputs 0 during reset, then one fresh pulse 5 edges after reset deassertion.
